// File: rtl/seg7led_tmr0_unit.sv
// Dual-digit hex 7-segment decoder plus a 32-bit reloadable down-counter
// timer that emits a one-cycle request on every expiry.
module seg7led_tmr0_unit (
    input  logic        clk,
    input  logic        rst,       // synchronous, active-low
    input  logic [7:0]  data,
    output logic [6:0]  seg7led1,
    output logic [6:0]  seg7led2,
    input  logic [31:0] din,
    input  logic        ld,
    input  logic        clr,
    input  logic        tmr_en,
    output logic        tmr_req,
    output logic [31:0] cntr_o
);

    // Active-low segment pattern for one hex nibble (bit0=a .. bit6=g).
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

    // Digit 1 is the high nibble, digit 0 the low nibble.
    logic [6:0] w_seg [2];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_digit
            // Purely combinational decode; independent of reset.
            always_comb begin
                w_seg[gi] = hex_to_seg(data[gi*4 +: 4]);
            end
        end
    endgenerate

    assign seg7led1 = w_seg[1];
    assign seg7led2 = w_seg[0];

    logic [31:0] r_cntr;
    logic [31:0] r_reload;
    logic        r_req;
    logic        w_cntr_zero;

    assign w_cntr_zero = (r_cntr == 32'd0);

    // Timer update: reset, clear, load, decrement, expiry/reload, hold.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cntr   <= 32'd0;
            r_reload <= 32'd0;
            r_req    <= 1'b0;
        end else if (clr) begin
            // A simultaneous load still captures the reload value, but the
            // counter stays cleared so the next enabled edge expires.
            r_cntr <= 32'd0;
            r_req  <= 1'b0;
            if (ld) begin
                r_reload <= din;
            end
        end else if (ld) begin
            r_cntr   <= din;
            r_reload <= din;
            r_req    <= 1'b0;
        end else if (tmr_en && !w_cntr_zero) begin
            r_cntr <= r_cntr - 32'd1;
            r_req  <= 1'b0;
        end else if (tmr_en) begin
            // Expiry: never wrap below zero, reload and pulse the request.
            r_cntr <= r_reload;
            r_req  <= 1'b1;
        end else begin
            r_req <= 1'b0;
        end
    end

    assign cntr_o  = r_cntr;
    assign tmr_req = r_req;

endmodule

// File: tb/tb_seg7led_tmr0_unit.sv
// Self-checking bench: decoder constant checks plus a scoreboarded
// cycle model of the timer, with explicit spot checks of key values.
module tb_seg7led_tmr0_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  data;
    logic [6:0]  seg7led1;
    logic [6:0]  seg7led2;
    logic [31:0] din;
    logic        ld;
    logic        clr;
    logic        tmr_en;
    logic        tmr_req;
    logic [31:0] cntr_o;

    always #5 clk = ~clk;

    seg7led_tmr0_unit dut (
        .clk      (clk),
        .rst      (rst),
        .data     (data),
        .seg7led1 (seg7led1),
        .seg7led2 (seg7led2),
        .din      (din),
        .ld       (ld),
        .clr      (clr),
        .tmr_en   (tmr_en),
        .tmr_req  (tmr_req),
        .cntr_o   (cntr_o)
    );

    int n_cmp = 0;
    int n_err = 0;

    typedef struct packed {
        logic [31:0] cnt;
        logic        req;
    } exp_t;

    exp_t sb_q[$];

    // Reference timer state
    logic [31:0] m_cnt = 32'd0;
    logic [31:0] m_rel = 32'd0;
    logic        m_req = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock of stimulus: drive at negedge, predict, check after posedge.
    task automatic step(input logic r, input logic l, input logic c,
                        input logic e, input logic [31:0] d);
        logic [31:0] n_cnt;
        logic [31:0] n_rel;
        logic        n_req;
        exp_t        ex;
        @(negedge clk);
        rst = r; ld = l; clr = c; tmr_en = e; din = d;
        n_cnt = m_cnt; n_rel = m_rel; n_req = 1'b0;
        if (!r) begin
            n_cnt = 0; n_rel = 0;
        end else if (c) begin
            n_cnt = 0;
            if (l) n_rel = d;
        end else if (l) begin
            n_cnt = d; n_rel = d;
        end else if (e && m_cnt != 0) begin
            n_cnt = m_cnt - 1;
        end else if (e) begin
            n_cnt = m_rel; n_req = 1'b1;
        end
        m_cnt = n_cnt; m_rel = n_rel; m_req = n_req;
        sb_q.push_back('{cnt: n_cnt, req: n_req});
        @(posedge clk);
        #1;
        ex = sb_q.pop_front();
        check("cntr_o", cntr_o, ex.cnt);
        check("tmr_req", {31'd0, tmr_req}, {31'd0, ex.req});
        $display("t=%0t rst=%b ld=%b clr=%b en=%b din=%0d -> cntr_o=%0d tmr_req=%b (exp %0d/%b)",
                 $time, r, l, c, e, d, cntr_o, tmr_req, ex.cnt, ex.req);
    endtask

    logic [7:0]  dec_in  [4] = '{8'h00, 8'h19, 8'hAF, 8'hFF};
    logic [13:0] dec_exp [4] = '{{7'h40, 7'h40}, {7'h79, 7'h10},
                                 {7'h08, 7'h0E}, {7'h0E, 7'h0E}};
    int seq_cnt [7] = '{2, 1, 0, 3, 2, 1, 0};
    int seq_req [7] = '{0, 0, 0, 1, 0, 0, 0};

    initial begin
        rst = 1'b0; ld = 1'b0; clr = 1'b0; tmr_en = 1'b0; din = 32'd0; data = 8'h00;

        // Decoder sweep, combinational
        for (int i = 0; i < 4; i++) begin
            data = dec_in[i];
            #1;
            check("seg7led1", {25'd0, seg7led1}, {25'd0, dec_exp[i][13:7]});
            check("seg7led2", {25'd0, seg7led2}, {25'd0, dec_exp[i][6:0]});
            $display("data=%h -> seg1=%h seg2=%h", data, seg7led1, seg7led2);
        end

        // Reset held with load asserted, then release
        step(0, 1, 0, 0, 32'd5);
        step(0, 1, 0, 0, 32'd5);
        check("rst_cntr", cntr_o, 32'd0);
        step(1, 0, 0, 0, 32'd5);
        step(1, 0, 0, 0, 32'd5);
        check("post_rst_cntr", cntr_o, 32'd0);

        // Periodic expiry with N=3
        step(1, 1, 0, 0, 32'd3);
        check("load3", cntr_o, 32'd3);
        for (int i = 0; i < 7; i++) begin
            step(1, 0, 0, 1, 32'd0);
            check("seq3_cnt", cntr_o, seq_cnt[i]);
            check("seq3_req", {31'd0, tmr_req}, seq_req[i]);
        end

        // Freeze and resume
        step(1, 1, 0, 0, 32'd10);
        for (int i = 0; i < 4; i++) step(1, 0, 0, 1, 32'd0);
        check("freeze_start", cntr_o, 32'd6);
        for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 32'd0);
        check("frozen", cntr_o, 32'd6);
        step(1, 0, 0, 1, 32'd0);
        check("resume5", cntr_o, 32'd5);
        step(1, 0, 0, 1, 32'd0);
        check("resume4", cntr_o, 32'd4);

        // clr+ld at an expiry edge suppresses expiry, next edge reloads 7
        step(1, 1, 0, 0, 32'd2);
        step(1, 0, 0, 1, 32'd0);
        step(1, 0, 0, 1, 32'd0);
        check("at_zero", cntr_o, 32'd0);
        step(1, 1, 1, 1, 32'd7);
        check("clr_cnt", cntr_o, 32'd0);
        check("clr_req", {31'd0, tmr_req}, 32'd0);
        step(1, 0, 0, 1, 32'd0);
        check("reload7_cnt", cntr_o, 32'd7);
        check("reload7_req", {31'd0, tmr_req}, 32'd1);

        // Reset mid-count zeroes the reload register too
        step(1, 0, 0, 1, 32'd0);
        step(0, 0, 0, 1, 32'd0);
        check("midrst_cnt", cntr_o, 32'd0);
        step(1, 0, 0, 1, 32'd0);
        check("midrst_req", {31'd0, tmr_req}, 32'd1);

        // Zero reload: request every cycle while enabled
        step(1, 1, 0, 0, 32'd0);
        for (int i = 0; i < 4; i++) begin
            step(1, 0, 0, 1, 32'd0);
            check("zero_req", {31'd0, tmr_req}, 32'd1);
            check("zero_cnt", cntr_o, 32'd0);
        end
        step(1, 0, 0, 0, 32'd0);
        check("zero_off_req", {31'd0, tmr_req}, 32'd0);

        // Decoder unaffected by reset
        data = 8'hC3;
        step(0, 0, 0, 0, 32'd0);
        check("seg_in_rst1", {25'd0, seg7led1}, 32'h46);
        check("seg_in_rst2", {25'd0, seg7led2}, 32'h30);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
